// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue between IF and ID: a small circular FIFO of {pc, ins, adel}
// with valid/ready on both sides. A flush empties it in one cycle, and an empty queue presents a NOP.
module ins_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_ins,
    input  logic             in_adel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_ins,
    output logic             out_adel,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_mem  [DEPTH];
    logic [31:0]      ins_mem [DEPTH];
    logic [DEPTH-1:0] adel_mem;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic             push;
    logic             pop;

    // in_ready depends on occupancy only, so a full queue refuses a push even when a pop happens in the same cycle
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty
    always_ff @(posedge clk) begin
        if (resetn && !flush && push) begin
            pc_mem[wptr]   <= in_pc;
            ins_mem[wptr]  <= in_adel ? 32'h0 : in_ins;
            adel_mem[wptr] <= in_adel;
        end
    end

    always_comb begin
        out_pc   = 32'h0;
        out_ins  = 32'h0;
        out_adel = 1'b0;
        if (out_valid) begin
            out_pc   = pc_mem[rptr];
            out_ins  = ins_mem[rptr];
            out_adel = adel_mem[rptr];
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the fetch buffer.
module tb_ins_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_ins;
    logic             in_adel;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_ins;
    logic             out_adel;
    logic [CNT_W-1:0] count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        adel;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    ins_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ins    (in_ins),
        .in_adel   (in_adel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_ins   (out_ins),
        .out_adel  (out_adel),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        ent_t head;
        head = (q.size() != 0) ? q[0] : '0;
        check("count",     32'(count),     32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
        check("out_pc",    out_pc,         head.pc);
        check("out_ins",   out_ins,        head.ins);
        check("out_adel",  32'(out_adel),  32'(head.adel));
    endtask

    // Drive one cycle, compare against the model mid-cycle, then advance the model across the edge.
    task automatic step(input logic rn, input logic fl, input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ad, input logic ordy, input bit chk);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        resetn    = rn;
        flush     = fl;
        in_valid  = iv;
        in_pc     = pc;
        in_ins    = ins;
        in_adel   = ad;
        out_ready = ordy;
        @(negedge clk);
        if (chk) check_model();
        do_push = iv && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() > 0);
        @(posedge clk);
        if (!rn || fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc   = pc;
                e.ins  = ad ? 32'h0 : ins;
                e.adel = ad;
                q.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
        in_ins = '0; in_adel = 1'b0; out_ready = 1'b0;
        #1;

        // Reset held for two cycles while IF offers a word
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        check("rst_count",    32'(count),     32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_out_ins",  out_ins,        32'h0);

        // Fill to full, then a rejected fifth push, then drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 32'hBFC0_0000 + 32'(4*i), 32'h2408_0001 + 32'(i), 1'b0, 1'b0, 1'b1);
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'hBFC0_0010, 32'h2408_0005, 1'b0, 1'b0, 1'b1);
        check("fifth_rejected", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at count 2, then at full
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hA000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'hA000_0002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'hA000_0003, 1'b0, 1'b1, 1'b1);
        check("pushpop_count2", 32'(count), 32'd2);
        check("pushpop_order",  out_ins,    32'hA000_0002);
        step(1'b1, 1'b0, 1'b1, 32'h0000_010C, 32'hA000_0004, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0110, 32'hA000_0005, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0114, 32'hA000_0006, 1'b0, 1'b1, 1'b1);
        check("full_pushpop_count", 32'(count), 32'd3);

        // Flush with a concurrent push at count 3
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1000_FFFF, 1'b0, 1'b0, 1'b1);
        check("flush_count",    32'(count),     32'd0);
        check("flush_valid",    32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready),  32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Streaming through the wrap point with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h0000_1000 + 32'(4*i), 32'(i + 1), 1'b0, 1'b1, 1'b1);
            check("stream_cnt_le1", 32'(count <= 1), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Fetch address error masks the instruction
        step(1'b1, 1'b0, 1'b1, 32'hBFC0_0002, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        check("adel_flag", 32'(out_adel), 32'd1);
        check("adel_ins",  out_ins,       32'h0);
        check("adel_pc",   out_pc,        32'hBFC0_0002);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Random traffic including occasional flushes and mid-stream resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(15) == 0), 1'($urandom),
                 $urandom, $urandom, ($urandom_range(7) == 0), 1'($urandom), 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
